// File: rtl/store_buffer_pkg.sv
// Shared store-buffer sizing and record types used by the buffer and its payload RAM.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 8;
  localparam int unsigned SB_IDX_W = 3;
  localparam int unsigned SB_PTR_W = 4;

  typedef logic [SB_IDX_W-1:0] sb_idx_t;
  typedef logic [SB_PTR_W-1:0] sb_ptr_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_payload_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic        committed;
    sb_payload_t payload;
  } sb_entry_t;

  // Occupancy between two wrap-tagged pointers.
  function automatic sb_ptr_t sb_dist(sb_ptr_t hi, sb_ptr_t lo);
    return hi - lo;
  endfunction

endpackage

// File: rtl/store_buffer_entry_ram.sv
// Payload storage for the store buffer: AGU write, allocate-clear and a head read port.
module store_buffer_entry_ram
  import store_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                agu_we_i,
  input  sb_idx_t             agu_idx_i,
  input  sb_payload_t         agu_wdata_i,
  input  logic [SB_DEPTH-1:0] clr_mask_i,
  input  sb_idx_t             rd_idx_i,
  output sb_payload_t         rd_data_o
);

  sb_payload_t mem_q [SB_DEPTH];

  // Payload deliberately has no reset; status bits in the parent gate its use.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (agu_we_i && (agu_idx_i == sb_idx_t'(i))) begin
        mem_q[i] <= agu_wdata_i;
      end else if (clr_mask_i[i]) begin
        mem_q[i] <= '0;
      end
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/store_buffer.sv
// Eight-entry in-order store buffer: allocate at rename, fill from AGU, commit, drain to memory.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_en1,
  input  logic                alloc_en2,
  output logic [SB_IDX_W-1:0] alloc_num1,
  output logic [SB_IDX_W-1:0] alloc_num2,
  output logic                sb_full,
  input  logic                agu_wen,
  input  logic [SB_IDX_W-1:0] agu_sbnum,
  input  logic [31:0]         agu_addr,
  input  logic [31:0]         agu_data,
  input  logic [3:0]          agu_be,
  input  logic                write1,
  input  logic [SB_IDX_W-1:0] sbnum1,
  input  logic                write2,
  input  logic [SB_IDX_W-1:0] sbnum2,
  input  logic                flush,
  output logic                mem_wen,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_data,
  output logic [3:0]          mem_be,
  input  logic                mem_ack,
  output logic                sb_empty
);

  sb_ptr_t             head_q, head_d;
  sb_ptr_t             cmt_q, cmt_d;
  sb_ptr_t             tail_q, tail_d;
  logic [SB_DEPTH-1:0] valid_q, valid_d;
  logic [SB_DEPTH-1:0] ready_q, ready_d;
  logic [SB_DEPTH-1:0] committed_q, committed_d;

  logic [SB_DEPTH-1:0] clr_mask;
  logic                agu_we;
  logic                drain_fire;
  sb_idx_t             head_idx;
  sb_ptr_t             count;
  sb_payload_t         agu_wdata;
  sb_payload_t         head_payload;

  assign head_idx   = head_q[SB_IDX_W-1:0];
  assign count      = sb_dist(tail_q, head_q);
  assign sb_full    = (count >= sb_ptr_t'(SB_DEPTH - 1));
  assign sb_empty   = (count == '0);
  assign alloc_num1 = tail_q[SB_IDX_W-1:0];
  assign alloc_num2 = tail_q[SB_IDX_W-1:0] + sb_idx_t'(alloc_en1);

  assign mem_wen    = valid_q[head_idx] & ready_q[head_idx] & committed_q[head_idx];
  assign mem_addr   = head_payload.addr;
  assign mem_data   = head_payload.data;
  assign mem_be     = head_payload.be;
  assign drain_fire = mem_wen & mem_ack;

  assign agu_wdata  = '{addr: agu_addr, data: agu_data, be: agu_be};

  always_comb begin
    head_d      = head_q;
    cmt_d       = cmt_q;
    tail_d      = tail_q;
    valid_d     = valid_q;
    ready_d     = ready_q;
    committed_d = committed_q;
    clr_mask    = '0;
    agu_we      = 1'b0;

    if (write1) begin
      committed_d[sbnum1] = 1'b1;
      cmt_d = cmt_q + sb_ptr_t'(1);
      if (write2) begin
        committed_d[sbnum2] = 1'b1;
        cmt_d = cmt_q + sb_ptr_t'(2);
      end
    end else if (write2) begin
      committed_d[sbnum2] = 1'b1;
      cmt_d = cmt_q + sb_ptr_t'(1);
    end

    if (drain_fire) begin
      valid_d[head_idx]     = 1'b0;
      ready_d[head_idx]     = 1'b0;
      committed_d[head_idx] = 1'b0;
      head_d                = head_q + sb_ptr_t'(1);
    end

    if (agu_wen && valid_q[agu_sbnum] && !committed_q[agu_sbnum]) begin
      agu_we             = 1'b1;
      ready_d[agu_sbnum] = 1'b1;
    end

    // Flush sees the post-commit cmt, so same-cycle commits survive; allocation is dropped.
    if (flush) begin
      for (int unsigned k = 0; k < SB_DEPTH; k++) begin
        if (sb_ptr_t'(k) < sb_dist(tail_q, cmt_d)) begin
          valid_d[cmt_d[SB_IDX_W-1:0] + sb_idx_t'(k)]     = 1'b0;
          ready_d[cmt_d[SB_IDX_W-1:0] + sb_idx_t'(k)]     = 1'b0;
          committed_d[cmt_d[SB_IDX_W-1:0] + sb_idx_t'(k)] = 1'b0;
        end
      end
      tail_d = cmt_d;
    end else if (!sb_full) begin
      if (alloc_en1) begin
        valid_d[alloc_num1]     = 1'b1;
        ready_d[alloc_num1]     = 1'b0;
        committed_d[alloc_num1] = 1'b0;
        clr_mask[alloc_num1]    = 1'b1;
      end
      if (alloc_en2) begin
        valid_d[alloc_num2]     = 1'b1;
        ready_d[alloc_num2]     = 1'b0;
        committed_d[alloc_num2] = 1'b0;
        clr_mask[alloc_num2]    = 1'b1;
      end
      tail_d = tail_q + sb_ptr_t'(alloc_en1) + sb_ptr_t'(alloc_en2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      cmt_q       <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      ready_q     <= '0;
      committed_q <= '0;
    end else begin
      head_q      <= head_d;
      cmt_q       <= cmt_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      committed_q <= committed_d;
    end
  end

  store_buffer_entry_ram u_entry_ram (
    .clk        (clk),
    .agu_we_i   (agu_we),
    .agu_idx_i  (agu_sbnum),
    .agu_wdata_i(agu_wdata),
    .clr_mask_i (clr_mask),
    .rd_idx_i   (head_idx),
    .rd_data_o  (head_payload)
  );

  // Committing an entry whose data has not arrived is a pipeline protocol error.
  commit1_ready_a: assert property (@(posedge clk) disable iff (rst) write1 |-> ready_q[sbnum1]);
  commit2_ready_a: assert property (@(posedge clk) disable iff (rst) write2 |-> ready_q[sbnum2]);

endmodule
